// File: rtl/io_port_unit_pkg.sv
// Shared definitions for the CPU I/O port unit.
// Word width, FIFO depth, holding-register states and MemtoReg select codes.
package io_port_unit_pkg;

    localparam int IO_DATA_W    = 16;
    localparam int IO_OUT_DEPTH = 4;

    // Input holding register state.
    typedef enum logic {
        H_EMPTY = 1'b0,
        H_FULL  = 1'b1
    } hold_state_t;

    // MemtoReg select codes used by the datapath write-back mux.
    typedef enum logic [1:0] {
        MTR_MEM = 2'b00,
        MTR_ALU = 2'b01,
        MTR_IO  = 2'b10
    } memtoreg_t;

endpackage

// File: rtl/io_port_unit_if.sv
// External device side of the I/O port unit: one valid/ready output
// stream (unit -> sink) and one valid/ready input stream (source -> unit).
//   out_valid/out_data/out_ready : output stream
//   in_valid/in_data/in_ready    : input stream
// master : the I/O port unit
// slave  : the external devices
interface io_port_unit_if #(
    parameter int DATA_W = io_port_unit_pkg::IO_DATA_W
);

    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready,
        input  in_valid,
        input  in_data,
        output in_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready,
        output in_valid,
        output in_data,
        input  in_ready
    );

endinterface

// File: rtl/io_out_fifo.sv
// Output FIFO for the I/O port unit; a write while full is dropped unless
// a pop frees a slot in the same cycle.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   wr_en, wr_data    : write request and word
//   rd_ready          : sink accepts head this cycle
//   rd_valid, rd_data : head valid and head word (0 when empty)
//   count             : occupancy 0..DEPTH
//   drop              : write rejected this cycle (full, no pop)
module io_out_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    assign pop  = rd_valid & rd_ready;
    // A pop in the same cycle frees the head slot, so a full FIFO
    // can still accept the new word.
    assign push = wr_en & (~full | pop);
    assign drop = wr_en & full & ~pop;

    assign rd_valid = ~empty;
    assign rd_data  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_port_unit.sv
// I/O stage of the 16-bit multicycle CPU: output FIFO fed by OutputWrite,
// 1-entry input holding register feeding MemtoReg input 2, sticky flags.
// Ports:
//   CLK, Reset          : clock, async active-low reset
//   OutputWrite,OutData : push request and word from the control path
//   InRead              : consume the held input word this cycle
//   InData              : held input word to the write-back mux
//   StatusClr           : clear both sticky flags
//   out_overflow        : sticky, OutputWrite dropped on a full FIFO
//   in_underflow        : sticky, InRead with holding register empty
//   out_count           : output FIFO occupancy
//   ext                 : external device valid/ready streams
module io_port_unit
    import io_port_unit_pkg::*;
#(
    parameter int DATA_W    = IO_DATA_W,
    parameter int OUT_DEPTH = IO_OUT_DEPTH
) (
    input  logic                       CLK,
    input  logic                       Reset,
    input  logic                       OutputWrite,
    input  logic [DATA_W-1:0]          OutData,
    input  logic                       InRead,
    output logic [DATA_W-1:0]          InData,
    input  logic                       StatusClr,
    output logic                       out_overflow,
    output logic                       in_underflow,
    output logic [$clog2(OUT_DEPTH):0] out_count,
    io_port_unit_if.master             ext
);

    logic fifo_drop;

    io_out_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (OUT_DEPTH)
    ) u_out_fifo (
        .clk      (CLK),
        .rst_n    (Reset),
        .wr_en    (OutputWrite),
        .wr_data  (OutData),
        .rd_ready (ext.out_ready),
        .rd_valid (ext.out_valid),
        .rd_data  (ext.out_data),
        .count    (out_count),
        .drop     (fifo_drop)
    );

    hold_state_t       state;
    hold_state_t       state_nxt;
    logic [DATA_W-1:0] hold_data;
    logic              capture;
    logic              underflow_evt;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state <= H_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // While full, a read frees the register but the word offered in that
    // same cycle is not taken: in_ready was low, so the source re-presents.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        unique case (state)
            H_EMPTY: begin
                if (ext.in_valid) begin
                    capture   = 1'b1;
                    state_nxt = H_FULL;
                end
            end
            H_FULL: begin
                if (InRead) begin
                    state_nxt = H_EMPTY;
                end
            end
            default: begin
                state_nxt = H_EMPTY;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            hold_data <= '0;
        end else if (capture) begin
            hold_data <= ext.in_data;
        end
    end

    assign ext.in_ready = (state == H_EMPTY);
    // Register output: the read sees the word held before this edge.
    assign InData       = hold_data;

    assign underflow_evt = InRead & (state == H_EMPTY);

    // A set event beats a simultaneous clear.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            out_overflow <= 1'b0;
            in_underflow <= 1'b0;
        end else begin
            out_overflow <= fifo_drop | (out_overflow & ~StatusClr);
            in_underflow <= underflow_evt | (in_underflow & ~StatusClr);
        end
    end

endmodule

// File: tb/tb_io_port_unit.sv
// Directed bench for io_port_unit with an output-stream scoreboard.
// Inputs change and outputs are checked 1ns after the rising edge.
module tb_io_port_unit;
    import io_port_unit_pkg::*;

    logic        CLK;
    logic        Reset;
    logic        OutputWrite;
    logic [15:0] OutData;
    logic        InRead;
    logic [15:0] InData;
    logic        StatusClr;
    logic        out_overflow;
    logic        in_underflow;
    logic [2:0]  out_count;

    int n_tests;
    int n_fail;

    logic [15:0] exp_q [$];

    io_port_unit_if #(.DATA_W(16)) dev ();

    io_port_unit #(
        .DATA_W    (16),
        .OUT_DEPTH (4)
    ) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .OutputWrite  (OutputWrite),
        .OutData      (OutData),
        .InRead       (InRead),
        .InData       (InData),
        .StatusClr    (StatusClr),
        .out_overflow (out_overflow),
        .in_underflow (in_underflow),
        .out_count    (out_count),
        .ext          (dev)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Score any transfer happening at the coming edge, then advance.
    task automatic tick();
        logic [15:0] e;
        if (dev.out_valid === 1'b1 && dev.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_pop", {16'h0, dev.out_data}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("sb_out_data", {16'h0, dev.out_data}, {16'h0, e});
            end
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        Reset         = 1'b0;
        OutputWrite   = 1'b0;
        OutData       = '0;
        InRead        = 1'b0;
        StatusClr     = 1'b0;
        dev.out_ready = 1'b0;
        dev.in_valid  = 1'b0;
        dev.in_data   = '0;
        #3;
        chk("rst_out_valid", {31'h0, dev.out_valid}, 0);
        chk("rst_out_data", {16'h0, dev.out_data}, 0);
        chk("rst_out_count", {29'h0, out_count}, 0);
        chk("rst_in_ready", {31'h0, dev.in_ready}, 1);
        chk("rst_indata", {16'h0, InData}, 0);
        chk("rst_ovf", {31'h0, out_overflow}, 0);
        chk("rst_unf", {31'h0, in_underflow}, 0);
        tick();
        Reset = 1'b1;
        tick();

        // Overflow: five writes into a stalled 4-deep FIFO.
        for (int i = 1; i <= 5; i++) begin
            OutputWrite = 1'b1;
            OutData     = 16'(i);
            if (i <= 4) exp_q.push_back(16'(i));
            tick();
        end
        OutputWrite = 1'b0;
        chk("t2_count", {29'h0, out_count}, 4);
        chk("t2_ovf", {31'h0, out_overflow}, 1);
        chk("t2_head_stable", {16'h0, dev.out_data}, 32'h0001);
        dev.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("t2_drained_valid", {31'h0, dev.out_valid}, 0);
        chk("t2_drained_count", {29'h0, out_count}, 0);
        dev.out_ready = 1'b0;
        StatusClr = 1'b1;
        tick();
        StatusClr = 1'b0;
        chk("t2_ovf_clr", {31'h0, out_overflow}, 0);

        // Push and pop on a full FIFO in the same cycle.
        for (int i = 0; i < 4; i++) begin
            OutputWrite = 1'b1;
            OutData     = 16'h0010 + 16'(i);
            exp_q.push_back(16'h0010 + 16'(i));
            tick();
        end
        dev.out_ready = 1'b1;
        OutData       = 16'hBEEF;
        exp_q.push_back(16'hBEEF);
        tick();
        OutputWrite = 1'b0;
        chk("t3_ovf", {31'h0, out_overflow}, 0);
        chk("t3_count", {29'h0, out_count}, 4);
        for (int i = 0; i < 4; i++) tick();
        chk("t3_drained_valid", {31'h0, dev.out_valid}, 0);
        dev.out_ready = 1'b0;

        // Capture then read.
        dev.in_valid = 1'b1;
        dev.in_data  = 16'hA5A5;
        tick();
        dev.in_valid = 1'b0;
        chk("t4_in_ready_low", {31'h0, dev.in_ready}, 0);
        InRead = 1'b1;
        chk("t4_indata", {16'h0, InData}, 32'hA5A5);
        tick();
        InRead = 1'b0;
        chk("t4_in_ready_high", {31'h0, dev.in_ready}, 1);
        chk("t4_unf", {31'h0, in_underflow}, 0);

        // Underflow, clear, and set-beats-clear.
        InRead = 1'b1;
        chk("t5_stale", {16'h0, InData}, 32'hA5A5);
        tick();
        InRead = 1'b0;
        chk("t5_unf_set", {31'h0, in_underflow}, 1);
        StatusClr = 1'b1;
        tick();
        StatusClr = 1'b0;
        chk("t5_unf_clr", {31'h0, in_underflow}, 0);
        StatusClr = 1'b1;
        InRead    = 1'b1;
        tick();
        StatusClr = 1'b0;
        InRead    = 1'b0;
        chk("t5_set_wins", {31'h0, in_underflow}, 1);
        StatusClr = 1'b1;
        tick();
        StatusClr = 1'b0;
        chk("t5_unf_clr2", {31'h0, in_underflow}, 0);

        // Read and offer in the same cycle while full.
        dev.in_valid = 1'b1;
        dev.in_data  = 16'h1111;
        tick();
        chk("t6_full", {31'h0, dev.in_ready}, 0);
        dev.in_data = 16'h2222;
        InRead      = 1'b1;
        chk("t6_old_word", {16'h0, InData}, 32'h1111);
        tick();
        InRead = 1'b0;
        chk("t6_not_captured", {31'h0, dev.in_ready}, 1);
        chk("t6_retained", {16'h0, InData}, 32'h1111);
        chk("t6_unf", {31'h0, in_underflow}, 0);
        tick();
        dev.in_valid = 1'b0;
        chk("t6_captured", {31'h0, dev.in_ready}, 0);
        InRead = 1'b1;
        chk("t6_new_word", {16'h0, InData}, 32'h2222);
        tick();
        InRead = 1'b0;
        chk("t6_empty", {31'h0, dev.in_ready}, 1);

        // Reset mid-run with three words queued and an input held.
        for (int i = 0; i < 3; i++) begin
            OutputWrite = 1'b1;
            OutData     = 16'h0C00 + 16'(i);
            tick();
        end
        OutputWrite  = 1'b0;
        dev.in_valid = 1'b1;
        dev.in_data  = 16'h7777;
        tick();
        dev.in_valid = 1'b0;
        InRead = 1'b1;
        tick();
        InRead = 1'b1;
        tick();
        InRead = 1'b0;
        chk("t1_pre_count", {29'h0, out_count}, 3);
        chk("t1_pre_unf", {31'h0, in_underflow}, 1);
        Reset = 1'b0;
        #1;
        chk("t1_count", {29'h0, out_count}, 0);
        chk("t1_out_valid", {31'h0, dev.out_valid}, 0);
        chk("t1_out_data", {16'h0, dev.out_data}, 0);
        chk("t1_in_ready", {31'h0, dev.in_ready}, 1);
        chk("t1_indata", {16'h0, InData}, 0);
        chk("t1_unf", {31'h0, in_underflow}, 0);
        chk("t1_ovf", {31'h0, out_overflow}, 0);
        tick();
        Reset = 1'b1;
        tick();
        chk("t1_after_count", {29'h0, out_count}, 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
